// File: rtl/hps_ext_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hps_ext_pkg : shared EXT_BUS bit map, command defaults and sizing helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package hps_ext_pkg;

  localparam int c_bus_dout_lo = 0;
  localparam int c_bus_dout_hi = 15;
  localparam int c_bus_din_lo  = 16;
  localparam int c_bus_din_hi  = 31;
  localparam int c_bus_dout_en = 32;
  localparam int c_bus_strobe  = 33;
  localparam int c_bus_enable  = 34;
  localparam int c_bus_spare   = 35;

  localparam logic [15:0] c_cmd_base_default = 16'h00F0;
  localparam int          c_status_idx       = 0;

  // Word counter must reach the status trailer (STW+1) and still saturate above it.
  function automatic int wcnt_width(input int stw, input int argw);
    int m;
    m = (stw > argw) ? stw : argw;
    return $clog2(m + 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hps_ext_cmd_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hps_ext_cmd_slot : sticky pending/overrun flags and committed args, one command
// Rev 1.0
// ---------------------------------------------------------------------------
module hps_ext_cmd_slot #(
  parameter int ARGW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_commit,
  input  logic                 i_ack,
  input  logic                 i_ovr_clr,
  input  logic [16*ARGW-1:0]   i_data,
  output logic                 o_pending,
  output logic                 o_overrun,
  output logic [16*ARGW-1:0]   o_arg
);

  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic [16*ARGW-1:0]   arg_q, arg_d;

  // Commit dominates ack, and a fresh overrun dominates the status-read clear.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    arg_d     = arg_q;
    if (i_ack)     pending_d = 1'b0;
    if (i_ovr_clr) overrun_d = 1'b0;
    if (i_commit) begin
      pending_d = 1'b1;
      arg_d     = i_data;
      if (pending_q && !i_ack) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      arg_q     <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      arg_q     <= arg_d;
    end
  end

  assign o_pending = pending_q;
  assign o_overrun = overrun_q;
  assign o_arg     = arg_q;

endmodule
`default_nettype wire

// File: rtl/hps_ext_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hps_ext_regfile : EXT_BUS command window with status snapshot and write slots
// Rev 1.0
// ---------------------------------------------------------------------------
module hps_ext_regfile
  import hps_ext_pkg::*;
#(
  parameter logic [15:0] CMD_BASE = c_cmd_base_default,
  parameter int          NCMD     = 8,
  parameter int          ARGW     = 2,
  parameter int          STW      = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  inout  wire  [35:0]               EXT_BUS,
  input  logic                      evt_toggle,
  input  logic [16*STW-1:0]         status_in,
  input  logic [NCMD-1:0]           cmd_ack,
  output logic [NCMD-1:0]           cmd_pending,
  output logic [NCMD-1:0]           cmd_overrun,
  output logic [16*ARGW*NCMD-1:0]   cmd_arg
);

  localparam int                  c_wcnt_w   = wcnt_width(STW, ARGW);
  localparam logic [c_wcnt_w-1:0] c_wcnt_max = '1;
  localparam logic [16:0]         c_win_lo   = {1'b0, CMD_BASE};
  localparam logic [16:0]         c_win_hi   = {1'b0, CMD_BASE} + 17'(NCMD);

  logic [15:0] w_din;
  logic        w_strobe;
  logic        w_enable;

  assign w_din    = EXT_BUS[c_bus_din_hi:c_bus_din_lo];
  assign w_strobe = EXT_BUS[c_bus_strobe];
  assign w_enable = EXT_BUS[c_bus_enable];

  logic [c_wcnt_w-1:0] wcnt_q, wcnt_d;
  logic [15:0]         cmd_q, cmd_d;
  logic [15:0]         dout_q, dout_d;
  logic                dout_en_q, dout_en_d;
  logic [7:0]          evt_cnt_q, evt_cnt_d;
  logic                evt_prev_q, evt_prev_d;
  logic [16*STW-1:0]   snap_q, snap_d;
  logic [16*ARGW-1:0]  shadow_q, shadow_d;

  logic        w_din_win;
  logic        w_cmd_win;
  logic        w_is_status;
  logic        w_commit_any;
  logic        w_ovr_clr;
  logic [15:0] w_cmd_off;
  logic [15:0] w_pend_ext;
  logic [15:0] w_ovr_ext;
  int          w_wcnt_int;

  // 17-bit compare keeps the window correct when CMD_BASE+NCMD crosses 16'hFFFF.
  assign w_din_win   = ({1'b0, w_din} >= c_win_lo) && ({1'b0, w_din} < c_win_hi);
  assign w_cmd_win   = ({1'b0, cmd_q} >= c_win_lo) && ({1'b0, cmd_q} < c_win_hi);
  assign w_cmd_off   = cmd_q - CMD_BASE;
  assign w_is_status = (w_cmd_off == 16'(c_status_idx));
  assign w_wcnt_int  = int'(wcnt_q);
  assign w_pend_ext  = 16'(cmd_pending);
  assign w_ovr_ext   = 16'(cmd_overrun);

  always_comb begin
    wcnt_d       = wcnt_q;
    cmd_d        = cmd_q;
    dout_d       = dout_q;
    dout_en_d    = dout_en_q;
    snap_d       = snap_q;
    shadow_d     = shadow_q;
    w_commit_any = 1'b0;
    w_ovr_clr    = 1'b0;
    evt_prev_d   = evt_toggle;
    evt_cnt_d    = evt_cnt_q + {7'd0, evt_toggle ^ evt_prev_q};

    if (!w_enable) begin
      wcnt_d    = '0;
      cmd_d     = '0;
      dout_d    = '0;
      dout_en_d = 1'b0;
      shadow_d  = '0;
    end else if (w_strobe) begin
      if (wcnt_q != c_wcnt_max) wcnt_d = wcnt_q + 1'b1;

      if (wcnt_q == '0) begin
        cmd_d     = w_din;
        dout_en_d = w_din_win;
        dout_d    = w_din_win ? {8'd0, evt_cnt_q} : 16'd0;
      end else if (w_cmd_win) begin
        if (w_is_status) begin
          if (w_wcnt_int == 1) begin
            snap_d = status_in;
            dout_d = status_in[15:0];
          end else if (w_wcnt_int <= STW) begin
            for (int k = 1; k < STW; k++) begin
              if (w_wcnt_int == k + 1) dout_d = snap_q[16*k +: 16];
            end
          end else if (w_wcnt_int == STW + 1) begin
            dout_d    = {w_ovr_ext[7:0], w_pend_ext[7:0]};
            w_ovr_clr = 1'b1;
          end else begin
            dout_d = '0;
          end
        end else if (w_wcnt_int <= ARGW) begin
          for (int k = 0; k < ARGW; k++) begin
            if (w_wcnt_int == k + 1) shadow_d[16*k +: 16] = w_din;
          end
          w_commit_any = (w_wcnt_int == ARGW);
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wcnt_q     <= '0;
      cmd_q      <= '0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
      evt_cnt_q  <= '0;
      evt_prev_q <= 1'b0;
      snap_q     <= '0;
      shadow_q   <= '0;
    end else begin
      wcnt_q     <= wcnt_d;
      cmd_q      <= cmd_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
      evt_cnt_q  <= evt_cnt_d;
      evt_prev_q <= evt_prev_d;
      snap_q     <= snap_d;
      shadow_q   <= shadow_d;
    end
  end

  assign EXT_BUS[c_bus_dout_hi:c_bus_dout_lo] = dout_q;
  assign EXT_BUS[c_bus_dout_en]               = dout_en_q;

  // Index 0 is the status read and owns no slot.
  assign cmd_pending[0]         = 1'b0;
  assign cmd_overrun[0]         = 1'b0;
  assign cmd_arg[16*ARGW-1:0]   = '0;

  for (genvar i = 1; i < NCMD; i++) begin : g_slot
    hps_ext_cmd_slot #(
      .ARGW (ARGW)
    ) u_slot (
      .clk       (clk_sys),
      .rst       (reset),
      .i_commit  (w_commit_any && (w_cmd_off == 16'(i))),
      .i_ack     (cmd_ack[i]),
      .i_ovr_clr (w_ovr_clr && (i < 8)),
      .i_data    (shadow_d),
      .o_pending (cmd_pending[i]),
      .o_overrun (cmd_overrun[i]),
      .o_arg     (cmd_arg[16*ARGW*i +: 16*ARGW])
    );
  end

  logic w_unused;
  assign w_unused = ^{cmd_ack[0], EXT_BUS[c_bus_spare], w_pend_ext[15:8], w_ovr_ext[15:8]};

endmodule
`default_nettype wire

// File: tb/tb_hps_ext_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hps_ext_regfile : scoreboard bench with a transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_hps_ext_regfile;

  localparam int          c_ncmd = 8;
  localparam int          c_argw = 2;
  localparam int          c_stw  = 8;
  localparam logic [15:0] c_base = 16'h00F0;
  localparam int          c_wmax = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] tb_din = '0;
  logic tb_strobe = 1'b0;
  logic tb_en = 1'b0;
  logic evt_toggle = 1'b0;
  logic [16*c_stw-1:0] status_in = '0;
  logic [c_ncmd-1:0] cmd_ack = '0;
  logic [c_ncmd-1:0] cmd_pending;
  logic [c_ncmd-1:0] cmd_overrun;
  logic [16*c_argw*c_ncmd-1:0] cmd_arg;
  wire  [35:0] ext_bus;

  assign ext_bus[31:16] = tb_din;
  assign ext_bus[33]    = tb_strobe;
  assign ext_bus[34]    = tb_en;

  hps_ext_regfile #(
    .CMD_BASE (c_base),
    .NCMD     (c_ncmd),
    .ARGW     (c_argw),
    .STW      (c_stw)
  ) dut (
    .clk_sys     (clk),
    .reset       (rst),
    .EXT_BUS     (ext_bus),
    .evt_toggle  (evt_toggle),
    .status_in   (status_in),
    .cmd_ack     (cmd_ack),
    .cmd_pending (cmd_pending),
    .cmd_overrun (cmd_overrun),
    .cmd_arg     (cmd_arg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        den;
    logic [15:0] dout;
    bit          chk_dout;
  } exp_t;

  exp_t exp_q[$];

  bit          m_pend [c_ncmd];
  bit          m_ovr  [c_ncmd];
  logic [15:0] m_arg  [c_ncmd][c_argw];
  logic [15:0] m_snap [c_stw];
  logic [15:0] m_shadow [c_argw];
  int          m_evt;
  int          m_wcnt;
  int          m_cmd;
  bit          m_inwin;
  logic [15:0] m_dout;
  logic        m_den;

  task automatic model_reset();
    for (int i = 0; i < c_ncmd; i++) begin
      m_pend[i] = 0;
      m_ovr[i]  = 0;
      for (int w = 0; w < c_argw; w++) m_arg[i][w] = '0;
    end
    m_evt  = 0;
    m_wcnt = 0;
    m_den  = 0;
    m_dout = '0;
  endtask

  // One strobe on the bus: returns what the DUT must present the next cycle.
  task automatic model_step(input logic [15:0] din, input logic [c_ncmd-1:0] ack, output exp_t e);
    int idx;
    int committed;
    logic [15:0] sw;
    committed = -1;
    e.chk_dout = 1;
    if (m_wcnt == 0) begin
      m_cmd   = int'(din);
      m_inwin = (m_cmd >= int'(c_base)) && (m_cmd < int'(c_base) + c_ncmd);
      m_den   = m_inwin;
      m_dout  = m_inwin ? 16'(m_evt) : 16'd0;
    end else if (m_inwin) begin
      idx = m_cmd - int'(c_base);
      if (idx == 0) begin
        if (m_wcnt == 1) begin
          for (int k = 0; k < c_stw; k++) m_snap[k] = status_in[16*k +: 16];
          m_dout = m_snap[0];
        end else if (m_wcnt <= c_stw) begin
          m_dout = m_snap[m_wcnt-1];
        end else if (m_wcnt == c_stw + 1) begin
          sw = '0;
          for (int k = 0; k < 8 && k < c_ncmd; k++) begin
            sw[k]     = m_pend[k];
            sw[8 + k] = m_ovr[k];
            m_ovr[k]  = 0;
          end
          m_dout = sw;
        end else begin
          m_dout = '0;
        end
      end else begin
        e.chk_dout = 0;
        if (m_wcnt <= c_argw) begin
          m_shadow[m_wcnt-1] = din;
          if (m_wcnt == c_argw) begin
            if (m_pend[idx] && !ack[idx]) m_ovr[idx] = 1;
            m_pend[idx] = 1;
            for (int w = 0; w < c_argw; w++) m_arg[idx][w] = m_shadow[w];
            committed = idx;
          end
        end
      end
    end
    for (int i = 1; i < c_ncmd; i++)
      if (ack[i] && i != committed) m_pend[i] = 0;
    m_wcnt = (m_wcnt < c_wmax) ? m_wcnt + 1 : c_wmax;
    e.den  = m_den;
    e.dout = m_dout;
  endtask

  // ---------------- monitor ----------------
  logic seen = 1'b0;
  exp_t mon_e;

  always @(posedge clk) seen <= tb_en && tb_strobe && !rst;

  always @(negedge clk) begin
    if (seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got bus response, want an expected entry");
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout_en", 64'(ext_bus[32]), 64'(mon_e.den));
        if (mon_e.chk_dout) chk("io_dout", 64'(ext_bus[15:0]), 64'(mon_e.dout));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] tx_w [0:31];

  function automatic logic [16*c_stw-1:0] rand_status();
    logic [16*c_stw-1:0] v;
    for (int k = 0; k < c_stw; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic check_side(input string tag);
    logic [c_ncmd-1:0] p;
    logic [c_ncmd-1:0] o;
    logic [16*c_argw-1:0] a;
    for (int i = 0; i < c_ncmd; i++) begin
      p[i] = m_pend[i];
      o[i] = m_ovr[i];
    end
    chk({tag, "_pending"}, 64'(cmd_pending), 64'(p));
    chk({tag, "_overrun"}, 64'(cmd_overrun), 64'(o));
    for (int i = 0; i < c_ncmd; i++) begin
      for (int w = 0; w < c_argw; w++) a[16*w +: 16] = m_arg[i][w];
      chk($sformatf("%s_arg%0d", tag, i), 64'(cmd_arg[16*c_argw*i +: 16*c_argw]), 64'(a));
    end
  endtask

  task automatic run_txn(input logic [15:0] code, input int nwords, input logic [c_ncmd-1:0] ack_last);
    exp_t e;
    m_wcnt = 0;
    for (int k = 0; k <= nwords; k++) begin
      @(negedge clk);
      if (k >= 2) status_in = rand_status();
      tb_en     = 1'b1;
      tb_strobe = 1'b1;
      tb_din    = (k == 0) ? code : tx_w[k-1];
      cmd_ack   = (k == nwords) ? ack_last : '0;
      model_step(tb_din, cmd_ack, e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    tb_strobe = 1'b0;
    cmd_ack   = '0;
    check_side("txn");
    @(negedge clk);
    tb_en = 1'b0;
    m_den = 0;
    m_dout = '0;
    @(negedge clk);
    chk("idle_dout", 64'(ext_bus[15:0]), 64'd0);
    chk("idle_den", 64'(ext_bus[32]), 64'd0);
  endtask

  task automatic toggle_evt();
    @(negedge clk);
    evt_toggle = ~evt_toggle;
    m_evt = (m_evt + 1) % 256;
    @(negedge clk);
  endtask

  task automatic ack_pulse(input logic [c_ncmd-1:0] mask);
    @(negedge clk);
    cmd_ack = mask;
    @(negedge clk);
    cmd_ack = '0;
    for (int i = 1; i < c_ncmd; i++) if (mask[i]) m_pend[i] = 0;
    chk("ack_pending", 64'(cmd_pending), 64'(mask & '0) | 64'(cmd_pending & ~mask));
    check_side("ack");
  endtask

  // ---------------- main sequence ----------------
  exp_t rst_e;
  logic [15:0] code;
  int nw;
  int r;
  logic [c_ncmd-1:0] ackm;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_side("reset");
    chk("reset_dout", 64'(ext_bus[15:0]), 64'd0);
    chk("reset_den", 64'(ext_bus[32]), 64'd0);
    rst = 1'b0;
    m_evt = int'(evt_toggle);
    repeat (2) @(negedge clk);

    // status read with three events
    repeat (3) toggle_evt();
    for (int k = 0; k < c_stw; k++) status_in[16*k +: 16] = 16'hA000 + 16'(k);
    run_txn(c_base, c_stw + 1, '0);

    // write commit and ack
    tx_w[0] = 16'h1234;
    tx_w[1] = 16'h5678;
    run_txn(c_base + 16'd3, 2, '0);
    chk("arg3_literal", 64'(cmd_arg[16*c_argw*3 +: 32]), 64'h56781234);
    chk("pend3_set", 64'(cmd_pending[3]), 64'd1);
    ack_pulse(8'h08);
    chk("pend3_clr", 64'(cmd_pending[3]), 64'd0);

    // overrun then status read clears it
    tx_w[0] = 16'h1111; tx_w[1] = 16'h2222;
    run_txn(c_base + 16'd2, 2, '0);
    tx_w[0] = 16'h3333; tx_w[1] = 16'h4444;
    run_txn(c_base + 16'd2, 2, '0);
    chk("ovr2_set", 64'(cmd_overrun[2]), 64'd1);
    run_txn(c_base, c_stw + 1, '0);
    chk("ovr2_cleared", 64'(cmd_overrun[2]), 64'd0);

    // ack colliding with commit
    run_txn(c_base + 16'd5, 2, '0);
    run_txn(c_base + 16'd5, 2, 8'h20);
    chk("collide_pend5", 64'(cmd_pending[5]), 64'd1);
    chk("collide_ovr5", 64'(cmd_overrun[5]), 64'd0);

    // aborted write leaves committed args alone
    tx_w[0] = 16'hAAAA; tx_w[1] = 16'hBBBB;
    run_txn(c_base + 16'd4, 2, '0);
    ack_pulse(8'h10);
    tx_w[0] = 16'hCCCC;
    run_txn(c_base + 16'd4, 1, '0);
    chk("abort_arg4", 64'(cmd_arg[16*c_argw*4 +: 32]), 64'hBBBBAAAA);
    chk("abort_pend4", 64'(cmd_pending[4]), 64'd0);

    // out-of-window codes on both sides
    run_txn(c_base + 16'd8, 3, '0);
    run_txn(c_base - 16'd1, 2, '0);

    // randomized traffic, including long reads that saturate the word counter
    repeat (60) begin
      r = int'($urandom_range(0, 9));
      if (r < 3) toggle_evt();
      if (r == 4) ack_pulse(c_ncmd'($urandom));
      code = 16'(int'(c_base) - 2 + int'($urandom_range(0, c_ncmd + 3)));
      nw = int'($urandom_range(0, 18));
      for (int w = 0; w < 32; w++) tx_w[w] = 16'($urandom);
      ackm = ($urandom_range(0, 3) == 0) ? c_ncmd'($urandom) : '0;
      status_in = rand_status();
      run_txn(code, nw, ackm);
    end

    // asynchronous reset in the middle of a write
    tx_w[0] = 16'h9999; tx_w[1] = 16'h8888;
    run_txn(c_base + 16'd6, 2, '0);
    m_wcnt = 0;
    @(negedge clk);
    tb_en = 1'b1; tb_strobe = 1'b1; tb_din = c_base + 16'd3;
    model_step(tb_din, '0, rst_e);
    exp_q.push_back(rst_e);
    @(negedge clk);
    tb_din = 16'hBEEF;
    model_step(tb_din, '0, rst_e);
    exp_q.push_back(rst_e);
    @(negedge clk);
    tb_strobe = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_side("midrst");
    chk("midrst_dout", 64'(ext_bus[15:0]), 64'd0);
    chk("midrst_den", 64'(ext_bus[32]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tb_en = 1'b0;
    m_evt = int'(evt_toggle);
    @(negedge clk);
    run_txn(c_base, c_stw + 1, '0);
    tx_w[0] = 16'h0F0F; tx_w[1] = 16'hF0F0;
    run_txn(c_base + 16'd7, 2, '0);
    chk("postrst_arg7", 64'(cmd_arg[16*c_argw*7 +: 32]), 64'hF0F00F0F);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
